// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures forwarded operands and decoded controls,
// detects load-use hazards, inserts bubbles, and obeys flush and global freeze.
module id_ex_reg #(
    parameter int CNT_W = 16
) (
    input  logic             in_clk,
    input  logic             in_RST,
    input  logic [31:0]      in_A,
    input  logic [31:0]      in_B,
    input  logic [4:0]       in_ra,
    input  logic [4:0]       in_rb,
    input  logic             in_use_ra,
    input  logic             in_use_rb,
    input  logic [4:0]       in_rw,
    input  logic             in_regwrite,
    input  logic             in_memread,
    input  logic             in_memwrite,
    input  logic             in_syscall,
    input  logic [3:0]       in_aluop,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_IDPCOUT,
    input  logic [31:0]      in_IDIS,
    input  logic [31:0]      in_EX_R,
    input  logic [4:0]       in_MEM_rw,
    input  logic [4:0]       in_WB_rw,
    input  logic             in_MEM_regwrite,
    input  logic             in_WB_regwrite,
    input  logic [31:0]      in_MEM_R,
    input  logic [31:0]      in_WB_W,
    input  logic             in_flush,
    input  logic             in_stall_ext,
    output logic [31:0]      out_EX_A,
    output logic [31:0]      out_EX_B,
    output logic [31:0]      out_EX_imm,
    output logic [31:0]      out_EX_PC,
    output logic [31:0]      out_EX_IS,
    output logic [4:0]       out_EX_rw,
    output logic             out_EX_regwrite,
    output logic             out_EX_memread,
    output logic             out_EX_memwrite,
    output logic             out_EX_syscall,
    output logic [3:0]       out_EX_aluop,
    output logic             out_EX_valid,
    output logic             out_stall,
    output logic [CNT_W-1:0] out_nbubble,
    output logic [CNT_W-1:0] out_nflush
);

    logic        ex_fwd_ok;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic        hz;
    logic        kill;
    logic        take;

    // A load in EX has no result yet, so it must never be forwarded from EX.
    assign ex_fwd_ok = out_EX_valid & out_EX_regwrite & ~out_EX_memread;

    always_comb begin
        fwd_a = in_A;
        if (in_ra != 5'd0) begin
            if (ex_fwd_ok && out_EX_rw == in_ra)
                fwd_a = in_EX_R;
            else if (in_MEM_regwrite && in_MEM_rw == in_ra)
                fwd_a = in_MEM_R;
            else if (in_WB_regwrite && in_WB_rw == in_ra)
                fwd_a = in_WB_W;
        end
    end

    always_comb begin
        fwd_b = in_B;
        if (in_rb != 5'd0) begin
            if (ex_fwd_ok && out_EX_rw == in_rb)
                fwd_b = in_EX_R;
            else if (in_MEM_regwrite && in_MEM_rw == in_rb)
                fwd_b = in_MEM_R;
            else if (in_WB_regwrite && in_WB_rw == in_rb)
                fwd_b = in_WB_W;
        end
    end

    assign hz = out_EX_valid & out_EX_memread & (out_EX_rw != 5'd0) &
                ((in_use_ra & (out_EX_rw == in_ra)) | (in_use_rb & (out_EX_rw == in_rb)));

    assign out_stall = hz & ~in_flush & ~in_stall_ext;

    // Flush beats freeze; a hazard only bubbles when the pipe is not frozen.
    assign kill = in_flush | (hz & ~in_stall_ext);
    assign take = ~in_flush & ~in_stall_ext & ~hz;

    always_ff @(posedge in_clk) begin
        if (in_RST || kill) begin
            out_EX_A        <= '0;
            out_EX_B        <= '0;
            out_EX_imm      <= '0;
            out_EX_PC       <= '0;
            out_EX_IS       <= '0;
            out_EX_rw       <= '0;
            out_EX_regwrite <= 1'b0;
            out_EX_memread  <= 1'b0;
            out_EX_memwrite <= 1'b0;
            out_EX_syscall  <= 1'b0;
            out_EX_aluop    <= '0;
            out_EX_valid    <= 1'b0;
        end else if (take) begin
            out_EX_A        <= fwd_a;
            out_EX_B        <= fwd_b;
            out_EX_imm      <= in_imm;
            out_EX_PC       <= in_IDPCOUT;
            out_EX_IS       <= in_IDIS;
            out_EX_rw       <= in_rw;
            out_EX_regwrite <= in_regwrite;
            out_EX_memread  <= in_memread;
            out_EX_memwrite <= in_memwrite;
            out_EX_syscall  <= in_syscall;
            out_EX_aluop    <= in_aluop;
            out_EX_valid    <= 1'b1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_RST) begin
            out_nbubble <= '0;
            out_nflush  <= '0;
        end else if (in_flush) begin
            if (out_nflush != '1)
                out_nflush <= out_nflush + CNT_W'(1);
        end else if (!in_stall_ext && hz) begin
            if (out_nbubble != '1)
                out_nbubble <= out_nbubble + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of the EX slot.
module tb_id_ex_reg;

    logic        in_clk, in_RST;
    logic [31:0] in_A, in_B, in_imm, in_IDPCOUT, in_IDIS, in_EX_R, in_MEM_R, in_WB_W;
    logic [4:0]  in_ra, in_rb, in_rw, in_MEM_rw, in_WB_rw;
    logic        in_use_ra, in_use_rb, in_regwrite, in_memread, in_memwrite, in_syscall;
    logic [3:0]  in_aluop;
    logic        in_MEM_regwrite, in_WB_regwrite, in_flush, in_stall_ext;

    logic [31:0] out_EX_A, out_EX_B, out_EX_imm, out_EX_PC, out_EX_IS;
    logic [4:0]  out_EX_rw;
    logic        out_EX_regwrite, out_EX_memread, out_EX_memwrite, out_EX_syscall;
    logic [3:0]  out_EX_aluop;
    logic        out_EX_valid, out_stall;
    logic [15:0] out_nbubble, out_nflush;

    logic [31:0] d4_A, d4_B, d4_imm, d4_PC, d4_IS;
    logic [4:0]  d4_rw;
    logic        d4_regwrite, d4_memread, d4_memwrite, d4_syscall, d4_valid, d4_stall;
    logic [3:0]  d4_aluop;
    logic [3:0]  d4_nbubble, d4_nflush;

    id_ex_reg dut (
        .in_clk(in_clk), .in_RST(in_RST), .in_A(in_A), .in_B(in_B),
        .in_ra(in_ra), .in_rb(in_rb), .in_use_ra(in_use_ra), .in_use_rb(in_use_rb),
        .in_rw(in_rw), .in_regwrite(in_regwrite), .in_memread(in_memread),
        .in_memwrite(in_memwrite), .in_syscall(in_syscall), .in_aluop(in_aluop),
        .in_imm(in_imm), .in_IDPCOUT(in_IDPCOUT), .in_IDIS(in_IDIS), .in_EX_R(in_EX_R),
        .in_MEM_rw(in_MEM_rw), .in_WB_rw(in_WB_rw), .in_MEM_regwrite(in_MEM_regwrite),
        .in_WB_regwrite(in_WB_regwrite), .in_MEM_R(in_MEM_R), .in_WB_W(in_WB_W),
        .in_flush(in_flush), .in_stall_ext(in_stall_ext),
        .out_EX_A(out_EX_A), .out_EX_B(out_EX_B), .out_EX_imm(out_EX_imm),
        .out_EX_PC(out_EX_PC), .out_EX_IS(out_EX_IS), .out_EX_rw(out_EX_rw),
        .out_EX_regwrite(out_EX_regwrite), .out_EX_memread(out_EX_memread),
        .out_EX_memwrite(out_EX_memwrite), .out_EX_syscall(out_EX_syscall),
        .out_EX_aluop(out_EX_aluop), .out_EX_valid(out_EX_valid), .out_stall(out_stall),
        .out_nbubble(out_nbubble), .out_nflush(out_nflush)
    );

    id_ex_reg #(.CNT_W(4)) dut4 (
        .in_clk(in_clk), .in_RST(in_RST), .in_A(in_A), .in_B(in_B),
        .in_ra(in_ra), .in_rb(in_rb), .in_use_ra(in_use_ra), .in_use_rb(in_use_rb),
        .in_rw(in_rw), .in_regwrite(in_regwrite), .in_memread(in_memread),
        .in_memwrite(in_memwrite), .in_syscall(in_syscall), .in_aluop(in_aluop),
        .in_imm(in_imm), .in_IDPCOUT(in_IDPCOUT), .in_IDIS(in_IDIS), .in_EX_R(in_EX_R),
        .in_MEM_rw(in_MEM_rw), .in_WB_rw(in_WB_rw), .in_MEM_regwrite(in_MEM_regwrite),
        .in_WB_regwrite(in_WB_regwrite), .in_MEM_R(in_MEM_R), .in_WB_W(in_WB_W),
        .in_flush(in_flush), .in_stall_ext(in_stall_ext),
        .out_EX_A(d4_A), .out_EX_B(d4_B), .out_EX_imm(d4_imm),
        .out_EX_PC(d4_PC), .out_EX_IS(d4_IS), .out_EX_rw(d4_rw),
        .out_EX_regwrite(d4_regwrite), .out_EX_memread(d4_memread),
        .out_EX_memwrite(d4_memwrite), .out_EX_syscall(d4_syscall),
        .out_EX_aluop(d4_aluop), .out_EX_valid(d4_valid), .out_stall(d4_stall),
        .out_nbubble(d4_nbubble), .out_nflush(d4_nflush)
    );

    typedef struct packed {
        logic        valid, regwrite, memread, memwrite, syscall;
        logic [4:0]  rw;
        logic [3:0]  aluop;
        logic [31:0] a, b, imm, pc, is;
    } ex_t;

    ex_t m;
    int  nb, nf;
    int  checks = 0;
    int  errors = 0;

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Value a consumer of register r should see, newest producer first.
    function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return rf;
        if (m.valid && m.regwrite && !m.memread && m.rw == r) return in_EX_R;
        if (in_MEM_regwrite && in_MEM_rw == r) return in_MEM_R;
        if (in_WB_regwrite && in_WB_rw == r) return in_WB_W;
        return rf;
    endfunction

    function automatic logic [31:0] sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    // One clock: check the combinational stall, advance the model, check the slot.
    task automatic applyStimulus();
        logic hz;
        ex_t  nxt;
        hz = m.valid && m.memread && m.rw != 0 &&
             ((in_use_ra && m.rw == in_ra) || (in_use_rb && m.rw == in_rb));
        #1;
        checkOutput("stall", {31'd0, out_stall}, {31'd0, hz && !in_flush && !in_stall_ext});
        nxt = m;
        if (in_RST) begin
            nxt = '0; nb = 0; nf = 0;
        end else if (in_flush) begin
            nxt = '0; nf++;
        end else if (in_stall_ext) begin
            nxt = m;
        end else if (hz) begin
            nxt = '0; nb++;
        end else begin
            nxt = '{valid: 1'b1, regwrite: in_regwrite, memread: in_memread,
                    memwrite: in_memwrite, syscall: in_syscall, rw: in_rw, aluop: in_aluop,
                    a: model_fwd(in_ra, in_A), b: model_fwd(in_rb, in_B),
                    imm: in_imm, pc: in_IDPCOUT, is: in_IDIS};
        end
        @(posedge in_clk);
        m = nxt;
        @(negedge in_clk);
        checkOutput("ctl", {18'd0, out_EX_valid, out_EX_regwrite, out_EX_memread, out_EX_memwrite,
                            out_EX_syscall, out_EX_rw, out_EX_aluop},
                    {18'd0, m.valid, m.regwrite, m.memread, m.memwrite, m.syscall, m.rw, m.aluop});
        checkOutput("ex_a", out_EX_A, m.a);
        checkOutput("ex_b", out_EX_B, m.b);
        checkOutput("ex_imm", out_EX_imm, m.imm);
        checkOutput("ex_pc", out_EX_PC, m.pc);
        checkOutput("ex_is", out_EX_IS, m.is);
        checkOutput("nbubble", {16'd0, out_nbubble}, sat(nb, 65535));
        checkOutput("nflush", {16'd0, out_nflush}, sat(nf, 65535));
        checkOutput("nbubble4", {28'd0, d4_nbubble}, sat(nb, 15));
        checkOutput("nflush4", {28'd0, d4_nflush}, sat(nf, 15));
    endtask

    task automatic clearInputs();
        {in_RST, in_A, in_B, in_ra, in_rb, in_use_ra, in_use_rb, in_rw} = '0;
        {in_regwrite, in_memread, in_memwrite, in_syscall, in_aluop, in_imm} = '0;
        {in_IDPCOUT, in_IDIS, in_EX_R, in_MEM_rw, in_WB_rw} = '0;
        {in_MEM_regwrite, in_WB_regwrite, in_MEM_R, in_WB_W, in_flush, in_stall_ext} = '0;
    endtask

    task automatic randomInputs(input bit allow_rst);
        in_A = $urandom; in_B = $urandom; in_imm = $urandom;
        in_IDPCOUT = $urandom; in_IDIS = $urandom;
        in_EX_R = $urandom; in_MEM_R = $urandom; in_WB_W = $urandom;
        in_ra = 5'($urandom_range(0, 3)); in_rb = 5'($urandom_range(0, 3));
        in_rw = 5'($urandom_range(0, 3));
        in_MEM_rw = 5'($urandom_range(0, 3)); in_WB_rw = 5'($urandom_range(0, 3));
        in_use_ra = 1'($urandom); in_use_rb = 1'($urandom);
        in_regwrite = 1'($urandom); in_memread = 1'($urandom_range(0, 2) == 0);
        in_memwrite = 1'($urandom); in_syscall = 1'($urandom_range(0, 7) == 0);
        in_aluop = 4'($urandom);
        in_MEM_regwrite = 1'($urandom); in_WB_regwrite = 1'($urandom);
        in_flush = 1'($urandom_range(0, 7) == 0);
        in_stall_ext = 1'($urandom_range(0, 7) == 0);
        in_RST = allow_rst && ($urandom_range(0, 31) == 0);
    endtask

    task automatic doReset();
        clearInputs();
        in_RST = 1'b1;
        applyStimulus();
        in_RST = 1'b0;
    endtask

    task automatic loadWord3();
        clearInputs();
        in_rw = 5'd3; in_regwrite = 1'b1; in_memread = 1'b1; in_IDIS = 32'h8c03_0000;
        applyStimulus();
    endtask

    task automatic addUsing3();
        clearInputs();
        in_rb = 5'd3; in_use_rb = 1'b1; in_rw = 5'd7; in_regwrite = 1'b1; in_B = 32'h55;
    endtask

    logic [31:0] frozen_a;

    initial begin
        clearInputs();
        in_RST = 1'b1;
        @(posedge in_clk);
        @(negedge in_clk);
        m = '0; nb = 0; nf = 0;

        // Reset held two cycles under random inputs.
        for (int i = 0; i < 2; i++) begin
            randomInputs(1'b0);
            in_RST = 1'b1;
            applyStimulus();
        end
        checkOutput("rst_valid", {31'd0, out_EX_valid}, 32'd0);
        checkOutput("rst_stall", {31'd0, out_stall}, 32'd0);

        // Forwarding priority EX > MEM > WB > regfile.
        doReset();
        in_rw = 5'd5; in_regwrite = 1'b1;
        applyStimulus();
        in_ra = 5'd5; in_use_ra = 1'b1; in_A = 32'h44; in_EX_R = 32'h11;
        in_MEM_rw = 5'd5; in_MEM_regwrite = 1'b1; in_MEM_R = 32'h22;
        in_WB_rw = 5'd5; in_WB_regwrite = 1'b1; in_WB_W = 32'h33;
        in_rw = 5'd0; in_regwrite = 1'b0;
        applyStimulus();
        checkOutput("fwd_ex", out_EX_A, 32'h11);
        applyStimulus();
        checkOutput("fwd_mem", out_EX_A, 32'h22);
        in_MEM_regwrite = 1'b0;
        applyStimulus();
        checkOutput("fwd_wb", out_EX_A, 32'h33);
        in_ra = 5'd0; in_MEM_rw = 5'd0; in_WB_rw = 5'd0; in_MEM_regwrite = 1'b1;
        applyStimulus();
        checkOutput("fwd_r0", out_EX_A, 32'h44);

        // Load-use: one bubble, then the value arrives via MEM.
        doReset();
        loadWord3();
        addUsing3();
        applyStimulus();
        checkOutput("lu_valid", {31'd0, out_EX_valid}, 32'd0);
        checkOutput("lu_nbubble", {16'd0, out_nbubble}, 32'd1);
        in_MEM_rw = 5'd3; in_MEM_regwrite = 1'b1; in_MEM_R = 32'h66;
        applyStimulus();
        checkOutput("lu_fwd", out_EX_B, 32'h66);
        checkOutput("lu_valid2", {31'd0, out_EX_valid}, 32'd1);

        // Flush coinciding with a load-use hazard.
        doReset();
        loadWord3();
        addUsing3();
        in_flush = 1'b1;
        applyStimulus();
        checkOutput("fl_valid", {31'd0, out_EX_valid}, 32'd0);
        checkOutput("fl_nflush", {16'd0, out_nflush}, 32'd1);
        checkOutput("fl_nbubble", {16'd0, out_nbubble}, 32'd0);

        // Freeze for three cycles, then release.
        doReset();
        in_A = 32'hcafe_0001; in_regwrite = 1'b1; in_rw = 5'd9;
        frozen_a = in_A;
        applyStimulus();
        in_stall_ext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_A = $urandom;
            applyStimulus();
            checkOutput("frz_a", out_EX_A, frozen_a);
        end
        in_stall_ext = 1'b0; in_A = 32'hbeef_0002;
        applyStimulus();
        checkOutput("frz_release", out_EX_A, 32'hbeef_0002);

        // Twenty load-use events saturate the 4-bit bubble counter.
        doReset();
        for (int i = 0; i < 20; i++) begin
            loadWord3();
            addUsing3();
            applyStimulus();
        end
        checkOutput("sat_nb4", {28'd0, d4_nbubble}, 32'hf);
        checkOutput("sat_nb16", {16'd0, out_nbubble}, 32'd20);

        // Random traffic with occasional reset, flush and freeze.
        doReset();
        for (int i = 0; i < 2000; i++) begin
            randomInputs(1'b1);
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
